// File: rtl/debug_pkg.sv
// Shared definitions for the debug snapshot serializer: FSM encoding and byte-count helper.
package debug_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitDone,
        StNext,
        StChecksum
    } ser_state_e;

    // Bytes per snapshot (data bytes only, excluding any checksum byte).
    function automatic int unsigned calc_bps(input int unsigned num_channels,
                                             input int unsigned data_width,
                                             input int unsigned word_length);
        return (num_channels * data_width) / word_length;
    endfunction

endpackage

// File: rtl/snapshot_byte_mux.sv
// Selects one byte of the latched snapshot: channel 0 first, each word MSB first.
module snapshot_byte_mux #(
    parameter int unsigned NUM_CHANNELS       = 4,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned OUTPUT_WORD_LENGTH = 8,
    parameter int unsigned IDX_W              = 5
) (
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] snapshot,
    input  logic [IDX_W-1:0]                   byte_idx,
    output logic [OUTPUT_WORD_LENGTH-1:0]      byte_out
);
    localparam int unsigned BPW = DATA_WIDTH / OUTPUT_WORD_LENGTH;
    localparam int unsigned BPS = NUM_CHANNELS * BPW;

    always_comb begin
        byte_out = '0;
        for (int b = 0; b < BPS; b++) begin
            if (byte_idx == IDX_W'(b)) begin
                byte_out = snapshot[(b / BPW) * DATA_WIDTH
                                    + (BPW - 1 - (b % BPW)) * OUTPUT_WORD_LENGTH
                                    +: OUTPUT_WORD_LENGTH];
            end
        end
    end

endmodule

// File: rtl/debug_snapshot_serializer.sv
// Latches NUM_CHANNELS state words on capture and streams them out byte by byte to a UART.
// Optional trailing checksum byte enabled by macro SNAPSHOT_CHECKSUM_EN.
module debug_snapshot_serializer
    import debug_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS       = 4,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned OUTPUT_WORD_LENGTH = 8
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_soft_reset,
    input  logic                               i_capture,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_channels,
    input  logic                               i_tx_done,
    output logic                               o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0]      o_data_tx,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_overrun
);
    localparam int unsigned BPS    = calc_bps(NUM_CHANNELS, DATA_WIDTH, OUTPUT_WORD_LENGTH);
    localparam int unsigned IDX_W  = $clog2(BPS + 1);
    localparam int unsigned SNAP_W = NUM_CHANNELS * DATA_WIDTH;

    ser_state_e                    state_q, state_d;
    logic [SNAP_W-1:0]             snap_q;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          overrun_q;
    logic [OUTPUT_WORD_LENGTH-1:0] mux_byte;
    logic                          last_data;
    logic                          final_byte;
    logic                          accept;

    snapshot_byte_mux #(
        .NUM_CHANNELS      (NUM_CHANNELS),
        .DATA_WIDTH        (DATA_WIDTH),
        .OUTPUT_WORD_LENGTH(OUTPUT_WORD_LENGTH),
        .IDX_W             (IDX_W)
    ) u_byte_mux (
        .snapshot(snap_q),
        .byte_idx(idx_q),
        .byte_out(mux_byte)
    );

    assign last_data = (idx_q == IDX_W'(BPS - 1));

`ifdef SNAPSHOT_CHECKSUM_EN
    logic [OUTPUT_WORD_LENGTH-1:0] sum_q;

    // Index BPS addresses the checksum byte once all data bytes are out.
    assign final_byte = (idx_q == IDX_W'(BPS));
    assign o_data_tx  = final_byte ? sum_q : mux_byte;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sum_q <= '0;
        end else if (!i_soft_reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state_q == StNext && idx_q < IDX_W'(BPS)) begin
            sum_q <= sum_q + mux_byte;
        end
    end
`else
    assign final_byte = last_data;
    assign o_data_tx  = mux_byte;
`endif

    assign o_tx_start = (state_q == StStart);
    assign o_done     = (state_q == StNext) && final_byte;
    // Busy drops in the done cycle so a coincident capture is taken as a new snapshot.
    assign o_busy     = (state_q != StIdle) && !o_done;
    assign o_overrun  = overrun_q;
    assign accept     = i_capture && !o_busy;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (i_capture) begin
                    state_d = StStart;
                    idx_d   = '0;
                end
            end
            StStart:    state_d = StWaitDone;
            StWaitDone: if (i_tx_done) state_d = StNext;
            StNext: begin
                if (final_byte) begin
                    state_d = i_capture ? StStart : StIdle;
                    if (i_capture) idx_d = '0;
`ifdef SNAPSHOT_CHECKSUM_EN
                end else if (last_data) begin
                    state_d = StChecksum;
                    idx_d   = IDX_W'(BPS);
`endif
                end else begin
                    state_d = StStart;
                    idx_d   = idx_q + 1'b1;
                end
            end
            StChecksum: state_d = StStart;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else if (!i_soft_reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) snap_q <= i_channels;
            if (i_capture && o_busy) overrun_q <= 1'b1;
        end
    end

endmodule

// File: doc/debug_snapshot_serializer.md
DEBUG_SNAPSHOT_SERIALIZER -- requirements
Module: debug_snapshot_serializer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, meaning the number of MIPS state words captured per snapshot (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the bit width of each channel word.
REQ-003 SHALL have parameter OUTPUT_WORD_LENGTH, default 8, meaning the UART byte width; DATA_WIDTH SHALL be an integer multiple of it.
REQ-004 SHALL have port i_clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_soft_reset  input  1  synchronous clear, active-low, same effect as i_reset.
REQ-007 SHALL have port i_capture  input  1  one-cycle request to latch and send a snapshot.
REQ-008 SHALL have port i_channels  input  NUM_CHANNELS*DATA_WIDTH  flattened channel words; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port i_tx_done  input  1  one-cycle pulse from the UART transmitter, byte finished.
REQ-010 SHALL have port o_tx_start  output  1  one-cycle pulse starting transmission of o_data_tx.
REQ-011 SHALL have port o_data_tx  output  OUTPUT_WORD_LENGTH  byte to transmit.
REQ-012 SHALL have port o_busy  output  1  high from capture acceptance until the last byte's i_tx_done.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse after the last byte completes.
REQ-014 SHALL have port o_overrun  output  1  sticky flag, capture requested while busy.

Function
REQ-015 SHALL, on i_capture while idle, latch all NUM_CHANNELS words into an internal snapshot register in that same edge; later i_channels changes SHALL not affect the transfer.
REQ-016 SHALL use FSM states IDLE, START, WAIT_DONE, NEXT (plus CHECKSUM, REQ-028): IDLE->START on capture; START->WAIT_DONE unconditionally; WAIT_DONE->NEXT on i_tx_done; NEXT->START if bytes remain, else ->IDLE.
REQ-017 SHALL assert o_tx_start for exactly one cycle in START, the cycle after capture acceptance for byte 0.
REQ-018 SHALL hold o_data_tx stable from the o_tx_start cycle until the matching i_tx_done.
REQ-019 SHALL send channel 0 first, each word most-significant byte first; total bytes BPS = NUM_CHANNELS*DATA_WIDTH/OUTPUT_WORD_LENGTH.
REQ-020 SHALL use a byte index counter of $clog2(BPS+1) bits that resets to 0 per snapshot and never wraps mid-transfer.
REQ-021 SHALL ignore i_tx_done in every state except WAIT_DONE, including the START cycle.
REQ-022 SHALL ignore i_capture while o_busy is high, and set o_overrun; o_overrun clears only on reset or soft reset.
REQ-023 SHALL, if i_capture arrives in the same cycle o_done pulses, accept it as a new snapshot (state IDLE that cycle).
REQ-024 SHALL pulse o_done in the NEXT cycle following the final byte's i_tx_done, with o_busy falling in the same cycle.

Reset
REQ-025 SHALL on i_reset low (any time) or i_soft_reset low (at the clock edge) force state IDLE, counters 0, snapshot register 0, o_tx_start 0, o_data_tx 0, o_busy 0, o_done 0, o_overrun 0.
REQ-026 SHALL abort an in-flight transfer on reset with no further o_tx_start; after release, the first accepted capture starts at byte 0.

Configuration
REQ-027 SHALL support macro SNAPSHOT_CHECKSUM_EN.
REQ-028 SHALL, with SNAPSHOT_CHECKSUM_EN defined, append one byte after the BPS data bytes: modulo-2^OUTPUT_WORD_LENGTH sum of all data bytes, sent via START/WAIT_DONE like a data byte; o_done follows its i_tx_done.
REQ-029 SHALL, without SNAPSHOT_CHECKSUM_EN, send exactly BPS bytes and contain no checksum logic.

Structure
REQ-030 SHALL place FSM state encoding and a function computing BPS in shared package debug_pkg.
REQ-031 SHALL be a single module; byte selection (snapshot word/byte mux) MAY be sub-module snapshot_byte_mux.

Verification
REQ-032 Defaults, channels {0x00000010,0x00000004,0x00400000,0xDEADBEEF}, capture, i_tx_done 5 cycles after each start -> 16 bytes 00 00 00 10 00 00 00 04 00 40 00 00 DE AD BE EF, o_done once, o_busy low after.
REQ-033 Change i_channels to all 0xFFFFFFFF one cycle after capture -> transmitted bytes unchanged from REQ-032.
REQ-034 Second i_capture during byte 3 -> ignored, o_overrun=1 until soft reset, still exactly 16 bytes sent.
REQ-035 Pulse i_tx_done while IDLE and in START cycle -> no state change, no extra byte.
REQ-036 Assert i_reset low during byte 7 -> all outputs 0 immediately; new capture sends 16 bytes from byte 0.
REQ-037 SNAPSHOT_CHECKSUM_EN, NUM_CHANNELS=1, word 0x01020304 -> bytes 01 02 03 04 0A, o_done after 0A completes.
